// File: rtl/rt_command_queue.sv
// Real-time command queue: 256-entry FIFO of timed DDS/interval commands, handed to the
// master-start synchronizer one per request edge; commands already past their start time are dropped.
//
// state | meaning
// INIT  | zero all RAM entries after reset (256 cycles)
// IDLE  | wait for a pending request with a non-empty queue
// READ  | head address presented to the RAM
// CHECK | head entry valid: deliver if still in the future, otherwise discard
module rt_command_queue (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        REQ_COMM,
    input  logic [63:0] TIME,
    input  logic        SYS_TIME_UPDATE,
    input  logic [47:0] FREQ,
    input  logic [47:0] FREQ_STEP,
    input  logic [31:0] FREQ_RATE,
    input  logic [63:0] TIME_START,
    input  logic [15:0] N_impulse,
    input  logic [1:0]  TYPE_impulse,
    input  logic [31:0] Interval_Ti,
    input  logic [31:0] Interval_Tp,
    input  logic [31:0] Tblank1,
    input  logic [31:0] Tblank2,
    input  logic        SPI_WR,
    output logic        DATA_WR,
    output logic [47:0] FREQ_z,
    output logic [47:0] FREQ_STEP_z,
    output logic [31:0] FREQ_RATE_z,
    output logic [63:0] TIME_START_z,
    output logic [15:0] N_impuls_z,
    output logic [1:0]  TYPE_impulse_z,
    output logic [31:0] Interval_Ti_z,
    output logic [31:0] Interval_Tp_z,
    output logic [31:0] Tblank1_z,
    output logic [31:0] Tblank2_z
);
    localparam int W = 338;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ, S_CHECK} state_t;
    state_t state, state_nxt;

    logic [W-1:0] mem [256];
    logic [W-1:0] ram_q;
    logic [W-1:0] wr_entry;
    logic [W-1:0] mem_wdata;
    logic [7:0]   mem_addr;
    logic         mem_we;

    logic [7:0] wr_ptr, rd_ptr, init_cnt;
    logic [8:0] count;
    logic       spi_q, spi_qq, req_q, req_qq, req_pending;
    logic       wr_edge, req_edge, enq, deq, deliver, head_valid;

    logic [47:0] h_freq, h_step;
    logic [31:0] h_rate;
    logic [63:0] h_ts;
    logic [15:0] h_n;
    logic [1:0]  h_type;
    logic [31:0] h_ti, h_tp, h_tb1, h_tb2;

    assign wr_entry = {FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse, TYPE_impulse,
                       Interval_Ti, Interval_Tp, Tblank1, Tblank2};
    assign {h_freq, h_step, h_rate, h_ts, h_n, h_type, h_ti, h_tp, h_tb1, h_tb2} = ram_q;

    assign wr_edge    = spi_q & ~spi_qq;
    assign req_edge   = req_q & ~req_qq;
    assign head_valid = h_ts > TIME;
    assign enq        = wr_edge && (state != S_INIT) && (count != 9'd256) && !SYS_TIME_UPDATE;

    // A flush outside INIT aborts any head evaluation in flight.
    always_comb begin
        state_nxt = state;
        deq       = 1'b0;
        deliver   = 1'b0;
        case (state)
            S_INIT:  if (init_cnt == 8'hFF) state_nxt = S_IDLE;
            S_IDLE:  if ((req_pending || req_edge) && (count != 9'd0)) state_nxt = S_READ;
            S_READ:  state_nxt = S_CHECK;
            S_CHECK: begin
                deq       = 1'b1;
                deliver   = head_valid;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (SYS_TIME_UPDATE && (state != S_INIT)) begin
            state_nxt = S_IDLE;
            deq       = 1'b0;
            deliver   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state <= S_INIT;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            spi_q       <= 1'b0;
            spi_qq      <= 1'b0;
            req_q       <= 1'b0;
            req_qq      <= 1'b0;
            req_pending <= 1'b0;
            init_cnt    <= 8'd0;
            wr_ptr      <= 8'd0;
            rd_ptr      <= 8'd0;
            count       <= 9'd0;
        end else begin
            spi_q       <= SPI_WR;
            spi_qq      <= spi_q;
            req_q       <= REQ_COMM;
            req_qq      <= req_q;
            req_pending <= (req_pending & ~deliver) | req_edge;
            if (state == S_INIT) init_cnt <= init_cnt + 8'd1;
            if (SYS_TIME_UPDATE) begin
                wr_ptr <= 8'd0;
                rd_ptr <= 8'd0;
                count  <= 9'd0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + 8'd1;
                if (deq) rd_ptr <= rd_ptr + 8'd1;
                count <= count + {8'd0, enq} - {8'd0, deq};
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            DATA_WR        <= 1'b0;
            FREQ_z         <= '0;
            FREQ_STEP_z    <= '0;
            FREQ_RATE_z    <= '0;
            TIME_START_z   <= '0;
            N_impuls_z     <= '0;
            TYPE_impulse_z <= '0;
            Interval_Ti_z  <= '0;
            Interval_Tp_z  <= '0;
            Tblank1_z      <= '0;
            Tblank2_z      <= '0;
        end else begin
            DATA_WR <= deliver;
            if (deliver) begin
                FREQ_z         <= h_freq;
                FREQ_STEP_z    <= h_step;
                FREQ_RATE_z    <= h_rate;
                TIME_START_z   <= h_ts;
                N_impuls_z     <= h_n;
                TYPE_impulse_z <= h_type;
                Interval_Ti_z  <= h_ti;
                Interval_Tp_z  <= h_tp;
                Tblank1_z      <= h_tb1;
                Tblank2_z      <= h_tb2;
            end
        end
    end

    assign mem_we    = (state == S_INIT) || enq;
    assign mem_addr  = (state == S_INIT) ? init_cnt : wr_ptr;
    assign mem_wdata = (state == S_INIT) ? '0 : wr_entry;

    // Head is read every cycle; the value captured while in READ is the one CHECK uses.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        ram_q <= mem[rd_ptr];
    end
endmodule

// File: tb/tb_rt_command_queue.sv
// Directed bench for rt_command_queue: a FIFO model predicts deliveries into a scoreboard,
// each DATA_WR pulse pops it and checks latency and every delivered field.
module tb_rt_command_queue;
    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        REQ_COMM = 1'b0;
    logic [63:0] TIME = 64'd300;
    logic        SYS_TIME_UPDATE = 1'b0;
    logic [47:0] FREQ = '0, FREQ_STEP = '0;
    logic [31:0] FREQ_RATE = '0;
    logic [63:0] TIME_START = '0;
    logic [15:0] N_impulse = '0;
    logic [1:0]  TYPE_impulse = '0;
    logic [31:0] Interval_Ti = '0, Interval_Tp = '0, Tblank1 = '0, Tblank2 = '0;
    logic        SPI_WR = 1'b0;
    logic        DATA_WR;
    logic [47:0] FREQ_z, FREQ_STEP_z;
    logic [31:0] FREQ_RATE_z;
    logic [63:0] TIME_START_z;
    logic [15:0] N_impuls_z;
    logic [1:0]  TYPE_impulse_z;
    logic [31:0] Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z;

    rt_command_queue dut (
        .CLK(CLK), .rst_n(rst_n), .REQ_COMM(REQ_COMM), .TIME(TIME),
        .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .FREQ(FREQ), .FREQ_STEP(FREQ_STEP),
        .FREQ_RATE(FREQ_RATE), .TIME_START(TIME_START), .N_impulse(N_impulse),
        .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp),
        .Tblank1(Tblank1), .Tblank2(Tblank2), .SPI_WR(SPI_WR), .DATA_WR(DATA_WR),
        .FREQ_z(FREQ_z), .FREQ_STEP_z(FREQ_STEP_z), .FREQ_RATE_z(FREQ_RATE_z),
        .TIME_START_z(TIME_START_z), .N_impuls_z(N_impuls_z), .TYPE_impulse_z(TYPE_impulse_z),
        .Interval_Ti_z(Interval_Ti_z), .Interval_Tp_z(Interval_Tp_z),
        .Tblank1_z(Tblank1_z), .Tblank2_z(Tblank2_z)
    );

    always #10 CLK = ~CLK;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] step;
        logic [31:0] rate;
        logic [63:0] ts;
        logic [15:0] n;
        logic [1:0]  typ;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } cmd_t;

    logic [337:0] zbus;
    assign zbus = {FREQ_z, FREQ_STEP_z, FREQ_RATE_z, TIME_START_z, N_impuls_z, TYPE_impulse_z,
                   Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z};

    int   n_cmp = 0, n_err = 0;
    int   n_deliv = 0, dw_cnt = 0, dw_consec = 0;
    logic dw_prev = 1'b0;
    bit   mpend = 1'b0;
    cmd_t mq[$];
    cmd_t sb[$];
    cmd_t last_out = '0;

    always @(negedge CLK) begin
        if (DATA_WR) begin
            dw_cnt++;
            if (dw_prev) dw_consec++;
        end
        dw_prev = DATA_WR;
    end

    function automatic cmd_t mk(input logic [47:0] f, input logic [63:0] ts, input logic [15:0] n);
        cmd_t c;
        c.freq = f;
        c.step = f ^ 48'h0000_5A5A_A5A5;
        c.rate = {16'h0, n} + 32'h100;
        c.ts   = ts;
        c.n    = n;
        c.typ  = n[1:0];
        c.ti   = ts[31:0] ^ 32'hDEAD;
        c.tp   = ts[31:0] + 32'h77;
        c.tb1  = {n, n};
        c.tb2  = ~ts[31:0];
        return c;
    endfunction

    task automatic chk(input string tag, input logic [337:0] obs, input logic [337:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference queue: serve the pending request, discarding heads that are already due.
    task automatic resolve();
        while (mpend && mq.size() > 0) begin
            cmd_t h;
            h = mq.pop_front();
            if (h.ts > TIME) begin
                sb.push_back(h);
                mpend = 1'b0;
                n_deliv++;
            end
        end
    endtask

    task automatic wait_dw(input int exp_lat, input string tag);
        int lat;
        cmd_t e;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK);
            #1;
            if (DATA_WR) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, 338'(lat), 338'(exp_lat));
        if (lat != 0) begin
            if (sb.size() == 0) chk({tag, " spurious"}, 338'(lat), 338'(0));
            else begin
                e = sb.pop_front();
                last_out = e;
                chk({tag, " cmd"}, zbus, e);
            end
        end
    endtask

    task automatic write_cmd(input cmd_t c, input int exp_lat, input string tag);
        @(negedge CLK);
        FREQ = c.freq; FREQ_STEP = c.step; FREQ_RATE = c.rate; TIME_START = c.ts;
        N_impulse = c.n; TYPE_impulse = c.typ; Interval_Ti = c.ti; Interval_Tp = c.tp;
        Tblank1 = c.tb1; Tblank2 = c.tb2;
        SPI_WR = 1'b1;
        if (mq.size() < 256) mq.push_back(c);
        resolve();
        @(posedge CLK);
        if (exp_lat != 0) wait_dw(exp_lat, tag);
        else repeat (2) @(posedge CLK);
        @(negedge CLK);
        SPI_WR = 1'b0;
        @(negedge CLK);
    endtask

    task automatic req_cmd(input int exp_lat, input string tag);
        @(negedge CLK);
        REQ_COMM = 1'b1;
        mpend = 1'b1;
        resolve();
        @(posedge CLK);
        wait_dw(exp_lat, tag);
        @(negedge CLK);
        REQ_COMM = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("reset DATA_WR", 338'(DATA_WR), 338'(0));
        chk("reset outputs", zbus, '0);
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (260) @(posedge CLK);
        #1;
        chk("init outputs", zbus, '0);
        chk("init no pulse", 338'(dw_cnt), 338'(0));

        // single command
        write_cmd(mk(48'h10_0000_0000, 64'h22C0, 16'd2), 0, "single wr");
        req_cmd(3, "single req");
        chk("single FREQ_z", 338'(FREQ_z), 338'(48'h10_0000_0000));
        chk("single TIME_START_z", 338'(TIME_START_z), 338'(64'h22C0));
        chk("single N_z", 338'(N_impuls_z), 338'(16'd2));

        // three in order
        write_cmd(mk(48'h111, 64'h22C0, 16'd5), 0, "order wr0");
        write_cmd(mk(48'h222, 64'h92C0, 16'd6), 0, "order wr1");
        write_cmd(mk(48'h333, 64'h225A5, 16'd7), 0, "order wr2");
        for (int i = 0; i < 3; i++) req_cmd(3, "order req");

        // expired head discarded
        @(negedge CLK);
        TIME = 64'h200;
        write_cmd(mk(48'h444, 64'h100, 16'd8), 0, "expire wr0");
        write_cmd(mk(48'h555, 64'h50000, 16'd9), 0, "expire wr1");
        req_cmd(6, "expire req");

        // request on empty queue, then write
        req_cmd(0, "empty req");
        write_cmd(mk(48'h666, 64'h40020, 16'd10), 4, "late wr");

        // flush keeps outputs and the pending request
        write_cmd(mk(48'h777, 64'h60000, 16'd11), 0, "flush wr0");
        write_cmd(mk(48'h888, 64'h60001, 16'd12), 0, "flush wr1");
        @(negedge CLK);
        SYS_TIME_UPDATE = 1'b1;
        mq.delete();
        @(negedge CLK);
        SYS_TIME_UPDATE = 1'b0;
        req_cmd(0, "flush req");
        chk("flush hold", zbus, last_out);
        write_cmd(mk(48'h999, 64'h70000, 16'd13), 4, "post-flush wr");

        // fill to full (257th dropped), then drain across the pointer wrap
        @(negedge CLK);
        TIME = 64'd300;
        for (int i = 0; i < 257; i++)
            write_cmd(mk(48'(i), 64'h1_0000_0000 + 64'(i), 16'(i)), 0, "fill wr");
        for (int i = 0; i < 256; i++) req_cmd(3, "drain req");
        req_cmd(0, "dropped 257th");

        chk("DATA_WR pulse count", 338'(dw_cnt), 338'(n_deliv));
        chk("DATA_WR back-to-back", 338'(dw_consec), 338'(0));
        chk("scoreboard empty", 338'(sb.size()), 338'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
